pulse_out_fifo: RTL and testbench

- Elastic buffer directly downstream of the processor core's pulse command output.
- Captures every 72-bit pulse command presented with a cstrobe pulse and holds it in order.
- Delivers commands to the signal-generator element over a valid/ready handshake, absorbing back-pressure without stalling the core.
- Reports fill level, sticky overflow and a saturating count of dropped commands for host readback.

---
 rtl/pulse_out_fifo_pkg.sv | 8 +
 rtl/pulse_out_fifo_if.sv | 24 ++
 rtl/pulse_fifo_mem.sv | 28 ++
 rtl/pulse_out_fifo.sv | 119 +++++++++++
 tb/tb_pulse_out_fifo.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/pulse_out_fifo_pkg.sv
// Shared constants for the pulse command output path; PULSE_OUT_WIDTH must match the core's cmd_out.
package pulse_out_fifo_pkg;

    localparam int PULSE_OUT_WIDTH        = 72;
    localparam int DEFAULT_ADDR_WIDTH     = 4;
    localparam int DEFAULT_DROP_CNT_WIDTH = 16;

endpackage

// File: rtl/pulse_out_fifo_if.sv
// Valid/ready handshake carrying pulse commands from the output FIFO to the signal generator.
interface pulse_out_fifo_if
    import pulse_out_fifo_pkg::*;
#(
    parameter int CMD_WIDTH = PULSE_OUT_WIDTH
) ();

    logic [CMD_WIDTH-1:0] pulse_data;
    logic                 pulse_valid;
    logic                 pulse_ready;

    modport master (
        output pulse_data,
        output pulse_valid,
        input  pulse_ready
    );

    modport slave (
        input  pulse_data,
        input  pulse_valid,
        output pulse_ready
    );

endinterface

// File: rtl/pulse_fifo_mem.sv
// Simple dual-port command RAM: synchronous write, synchronous read with read enable.
module pulse_fifo_mem
    import pulse_out_fifo_pkg::*;
#(
    parameter int CMD_WIDTH  = PULSE_OUT_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [CMD_WIDTH-1:0]  wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [CMD_WIDTH-1:0]  rd_data
);

    logic [CMD_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/pulse_out_fifo.sv
// Elastic show-ahead FIFO between the core's pulse command output and the signal generator,
// with fill level, sticky overflow and a saturating dropped-command counter.
module pulse_out_fifo
    import pulse_out_fifo_pkg::*;
#(
    parameter int CMD_WIDTH      = PULSE_OUT_WIDTH,
    parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
    parameter int DROP_CNT_WIDTH = DEFAULT_DROP_CNT_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CMD_WIDTH-1:0]      cmd_in,
    input  logic                      cstrobe,
    pulse_out_fifo_if.master          pulse,
    output logic [ADDR_WIDTH:0]       fill_count,
    output logic                      full,
    output logic                      overflow,
    input  logic                      overflow_clear,
    output logic [DROP_CNT_WIDTH-1:0] drop_count
);

    localparam logic [ADDR_WIDTH:0] FULL_LEVEL = (ADDR_WIDTH+1)'(1 << ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] COUNT_ONE  = (ADDR_WIDTH+1)'(1);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH-1:0] rd_next;
    logic [ADDR_WIDTH:0]   count_next;
    logic                  push;
    logic                  pop;
    logic                  drop;
    logic                  load_bypass;
    logic                  load_ram;
    logic                  head_valid;
    logic                  head_from_ram;
    logic [CMD_WIDTH-1:0]  bypass_q;
    logic [CMD_WIDTH-1:0]  ram_q;

    assign full    = (fill_count == FULL_LEVEL);
    assign pop     = head_valid & pulse.pulse_ready;
    assign push    = cstrobe & (~full | pop);
    assign drop    = cstrobe & full & ~pop;
    assign rd_next = rd_ptr + ADDR_WIDTH'(1);

    // The head comes straight from cmd_in when the new command is the only entry;
    // otherwise the RAM is read one entry ahead of the departing head.
    assign load_bypass = push & ((fill_count == '0) | (pop & (fill_count == COUNT_ONE)));
    assign load_ram    = pop & (fill_count > COUNT_ONE);

    assign pulse.pulse_valid = head_valid;
    assign pulse.pulse_data  = head_from_ram ? ram_q : bypass_q;

    pulse_fifo_mem #(
        .CMD_WIDTH  (CMD_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data (cmd_in),
        .rd_en   (load_ram),
        .rd_addr (rd_next),
        .rd_data (ram_q)
    );

    always_comb begin
        count_next = fill_count;
        if (push && !pop) begin
            count_next = fill_count + COUNT_ONE;
        end else if (pop && !push) begin
            count_next = fill_count - COUNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fill_count    <= '0;
            head_valid    <= 1'b0;
            head_from_ram <= 1'b0;
            bypass_q      <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr <= rd_next;
            end
            fill_count <= count_next;
            head_valid <= (count_next != '0);
            if (load_bypass) begin
                bypass_q      <= cmd_in;
                head_from_ram <= 1'b0;
            end else if (load_ram) begin
                head_from_ram <= 1'b1;
            end
        end
    end

    // A drop in the same cycle as a clear restarts the count at one rather than zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (overflow_clear) begin
                drop_count <= DROP_CNT_WIDTH'(1);
            end else if (drop_count != '1) begin
                drop_count <= drop_count + DROP_CNT_WIDTH'(1);
            end
        end else if (overflow_clear) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end
    end

endmodule

// File: tb/tb_pulse_out_fifo.sv
// Randomized self-checking bench for pulse_out_fifo against a queue-based reference model.
module tb_pulse_out_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic [71:0] cmd_in;
    logic        cstrobe;
    logic [4:0]  fill_count;
    logic        full;
    logic        overflow;
    logic        overflow_clear;
    logic [15:0] drop_count;

    pulse_out_fifo_if #(.CMD_WIDTH(72)) pif ();

    pulse_out_fifo dut (
        .clk            (clk),
        .reset          (reset),
        .cmd_in         (cmd_in),
        .cstrobe        (cstrobe),
        .pulse          (pif),
        .fill_count     (fill_count),
        .full           (full),
        .overflow       (overflow),
        .overflow_clear (overflow_clear),
        .drop_count     (drop_count)
    );

    always #5 clk = ~clk;

    logic [71:0] model_q[$];
    logic        m_ovf;
    logic [15:0] m_drops;
    int          total = 0;
    int          bad = 0;

    // One clock edge: the model consumes the inputs held across the edge, then outputs are sampled 1ns later.
    task automatic cycle();
        bit m_valid, m_pop, m_full, m_push, m_drop;
        @(posedge clk);
        if (reset) begin
            model_q.delete();
            m_ovf   = 1'b0;
            m_drops = '0;
        end else begin
            m_valid = (model_q.size() > 0);
            m_pop   = m_valid && pif.pulse_ready;
            m_full  = (model_q.size() == 16);
            m_push  = cstrobe && (!m_full || m_pop);
            m_drop  = cstrobe && m_full && !m_pop;
            if (m_pop) void'(model_q.pop_front());
            if (m_push) model_q.push_back(cmd_in);
            if (m_drop) begin
                m_ovf   = 1'b1;
                m_drops = overflow_clear ? 16'd1 : ((m_drops == 16'hFFFF) ? m_drops : m_drops + 16'd1);
            end else if (overflow_clear) begin
                m_ovf   = 1'b0;
                m_drops = '0;
            end
        end
        #1;
    endtask

    task automatic push_values(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            cmd_in  = 72'(base + i);
            cstrobe = 1'b1;
            cycle();
        end
        cstrobe = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; cmd_in = '0; cstrobe = 1'b0; overflow_clear = 1'b0; pif.pulse_ready = 1'b0;
        repeat (3) cycle();
        total++; if (pif.pulse_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b want 0", pif.pulse_valid); end
        total++; if (fill_count !== 5'd0) begin bad++; $display("FAIL reset_fill: got %0d want 0", fill_count); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full: got %0b want 0", full); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %0b want 0", overflow); end
        total++; if (drop_count !== 16'd0) begin bad++; $display("FAIL reset_drop_count: got %0d want 0", drop_count); end
        reset = 1'b0;
    endtask

    task automatic test_single_push();
        logic [71:0] v;
        v = 72'h0A_DEADBEEF_12345678;
        repeat (2) cycle();
        cmd_in = v; cstrobe = 1'b1;
        cycle();
        cstrobe = 1'b0;
        total++; if (pif.pulse_valid !== 1'b1) begin bad++; $display("FAIL single_valid: got %0b want 1", pif.pulse_valid); end
        total++; if (pif.pulse_data !== v) begin bad++; $display("FAIL single_data: got %h want %h", pif.pulse_data, v); end
        total++; if (fill_count !== 5'd1) begin bad++; $display("FAIL single_fill: got %0d want 1", fill_count); end
        cycle();
        total++; if (pif.pulse_data !== v) begin bad++; $display("FAIL single_hold: got %h want %h", pif.pulse_data, v); end
        pif.pulse_ready = 1'b1;
        cycle();
        pif.pulse_ready = 1'b0;
        total++; if (pif.pulse_valid !== 1'b0) begin bad++; $display("FAIL single_pop_valid: got %0b want 0", pif.pulse_valid); end
        total++; if (fill_count !== 5'd0) begin bad++; $display("FAIL single_pop_fill: got %0d want 0", fill_count); end
    endtask

    task automatic test_fill_overflow();
        pif.pulse_ready = 1'b0;
        push_values(16, 0);
        total++; if (full !== 1'b1) begin bad++; $display("FAIL fill_full: got %0b want 1", full); end
        total++; if (fill_count !== 5'd16) begin bad++; $display("FAIL fill_count16: got %0d want 16", fill_count); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fill_no_overflow: got %0b want 0", overflow); end
        push_values(1, 16);
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL drop_overflow: got %0b want 1", overflow); end
        total++; if (drop_count !== 16'd1) begin bad++; $display("FAIL drop_count1: got %0d want 1", drop_count); end
        total++; if (fill_count !== 5'd16) begin bad++; $display("FAIL drop_fill: got %0d want 16", fill_count); end
        pif.pulse_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            total++; if (pif.pulse_valid !== 1'b1) begin bad++; $display("FAIL drain_valid[%0d]: got %0b want 1", i, pif.pulse_valid); end
            total++; if (pif.pulse_data !== 72'(i)) begin bad++; $display("FAIL drain_data[%0d]: got %0d want %0d", i, pif.pulse_data, i); end
            cycle();
        end
        pif.pulse_ready = 1'b0;
        total++; if (pif.pulse_valid !== 1'b0) begin bad++; $display("FAIL drain_empty: got %0b want 0", pif.pulse_valid); end
    endtask

    task automatic test_overflow_clear();
        overflow_clear = 1'b1;
        cycle();
        overflow_clear = 1'b0;
        total++; if (overflow !== 1'b0 || drop_count !== 16'd0) begin bad++; $display("FAIL clear_initial: got ovf=%0b cnt=%0d want 0/0", overflow, drop_count); end
        push_values(16, 200);
        push_values(3, 300);
        total++; if (drop_count !== 16'd3 || overflow !== 1'b1) begin bad++; $display("FAIL drop3: got ovf=%0b cnt=%0d want 1/3", overflow, drop_count); end
        overflow_clear = 1'b1;
        cycle();
        overflow_clear = 1'b0;
        total++; if (overflow !== 1'b0 || drop_count !== 16'd0) begin bad++; $display("FAIL clear_after_drops: got ovf=%0b cnt=%0d want 0/0", overflow, drop_count); end
        push_values(2, 400);
        overflow_clear = 1'b1; cmd_in = 72'd500; cstrobe = 1'b1;
        cycle();
        overflow_clear = 1'b0; cstrobe = 1'b0;
        total++; if (overflow !== 1'b1 || drop_count !== 16'd1) begin bad++; $display("FAIL clear_with_drop: got ovf=%0b cnt=%0d want 1/1", overflow, drop_count); end
        pif.pulse_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            total++; if (pif.pulse_data !== 72'(200 + i)) begin bad++; $display("FAIL clear_drain[%0d]: got %0d want %0d", i, pif.pulse_data, 200 + i); end
            cycle();
        end
        pif.pulse_ready = 1'b0;
    endtask

    task automatic test_full_push_pop();
        logic [15:0] drops_before;
        push_values(16, 100);
        drops_before = m_drops;
        cmd_in = 72'd99; cstrobe = 1'b1; pif.pulse_ready = 1'b1;
        cycle();
        cstrobe = 1'b0;
        total++; if (fill_count !== 5'd16) begin bad++; $display("FAIL pp_full_fill: got %0d want 16", fill_count); end
        total++; if (drop_count !== drops_before) begin bad++; $display("FAIL pp_full_nodrop: got %0d want %0d", drop_count, drops_before); end
        for (int i = 0; i < 16; i++) begin
            total++; if (pif.pulse_data !== model_q[0]) begin bad++; $display("FAIL pp_drain[%0d]: got %0d want %0d", i, pif.pulse_data, model_q[0]); end
            if (i == 15) begin
                total++; if (pif.pulse_data !== 72'd99) begin bad++; $display("FAIL pp_last99: got %0d want 99", pif.pulse_data); end
            end
            cycle();
        end
        pif.pulse_ready = 1'b0;
        push_values(16, 600);
        pif.pulse_ready = 1'b1; cstrobe = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cmd_in = {$urandom, $urandom, 8'($urandom)};
            cycle();
            total++; if (fill_count !== 5'd16 || pif.pulse_data !== model_q[0]) begin bad++; $display("FAIL pp_wrap[%0d]: got fill=%0d data=%h want 16/%h", i, fill_count, pif.pulse_data, model_q[0]); end
        end
        cstrobe = 1'b0;
        for (int i = 0; i < 16; i++) begin
            total++; if (pif.pulse_data !== model_q[0]) begin bad++; $display("FAIL pp_wrap_drain[%0d]: got %h want %h", i, pif.pulse_data, model_q[0]); end
            cycle();
        end
        pif.pulse_ready = 1'b0;
    endtask

    task automatic test_back_pressure();
        logic [71:0] held;
        bit          stalled;
        for (int i = 0; i < 400; i++) begin
            cstrobe         = ($urandom_range(0, 9) < 6);
            cmd_in          = {$urandom, $urandom, 8'($urandom)};
            pif.pulse_ready = ($urandom_range(0, 2) == 0);
            overflow_clear  = ($urandom_range(0, 49) == 0);
            stalled = (pif.pulse_valid === 1'b1) && !pif.pulse_ready;
            held    = pif.pulse_data;
            cycle();
            total++; if (pif.pulse_valid !== (model_q.size() > 0)) begin bad++; $display("FAIL bp_valid[%0d]: got %0b want %0b", i, pif.pulse_valid, model_q.size() > 0); end
            if (model_q.size() > 0) begin
                total++; if (pif.pulse_data !== model_q[0]) begin bad++; $display("FAIL bp_data[%0d]: got %h want %h", i, pif.pulse_data, model_q[0]); end
            end
            if (stalled) begin
                total++; if (pif.pulse_data !== held) begin bad++; $display("FAIL bp_stable[%0d]: got %h want %h", i, pif.pulse_data, held); end
            end
            total++; if (fill_count !== 5'(model_q.size()) || full !== (model_q.size() == 16)) begin bad++; $display("FAIL bp_fill[%0d]: got %0d/%0b want %0d", i, fill_count, full, model_q.size()); end
            total++; if (overflow !== m_ovf || drop_count !== m_drops) begin bad++; $display("FAIL bp_flags[%0d]: got %0b/%0d want %0b/%0d", i, overflow, drop_count, m_ovf, m_drops); end
        end
        cstrobe = 1'b0; overflow_clear = 1'b0; pif.pulse_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        pif.pulse_ready = 1'b1;
        repeat (18) cycle();
        pif.pulse_ready = 1'b0;
        push_values(5, 700);
        total++; if (fill_count !== 5'd5) begin bad++; $display("FAIL mid_pre_fill: got %0d want 5", fill_count); end
        #2 reset = 1'b1;
        #1;
        total++; if (pif.pulse_valid !== 1'b0) begin bad++; $display("FAIL mid_reset_valid: got %0b want 0", pif.pulse_valid); end
        total++; if (fill_count !== 5'd0) begin bad++; $display("FAIL mid_reset_fill: got %0d want 0", fill_count); end
        total++; if (overflow !== 1'b0 || drop_count !== 16'd0) begin bad++; $display("FAIL mid_reset_flags: got %0b/%0d want 0/0", overflow, drop_count); end
        model_q.delete(); m_ovf = 1'b0; m_drops = '0;
        #2 reset = 1'b0;
        cmd_in = 72'd7; cstrobe = 1'b1;
        cycle();
        cstrobe = 1'b0;
        total++; if (pif.pulse_valid !== 1'b1 || pif.pulse_data !== 72'd7) begin bad++; $display("FAIL mid_after_push: got %0b/%0d want 1/7", pif.pulse_valid, pif.pulse_data); end
        total++; if (fill_count !== 5'd1) begin bad++; $display("FAIL mid_after_fill: got %0d want 1", fill_count); end
    endtask

    initial begin
        m_ovf = 1'b0;
        m_drops = '0;
        test_reset();
        test_single_push();
        test_fill_overflow();
        test_overflow_clear();
        test_full_push_pop();
        test_back_pressure();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
